ram_loader: RTL

Bus-side initiator for the 8-bit computer's RAM: streams a program image into all RAM_SIZE locations through the RAM's write port, and dumps the full contents back out through the RAM's read port. It drives the same address, data, ram_in and ram_out signals the control unit drives during normal execution. It takes ownership of the RAM bus only while `busy` is high; outside that window the bus is muxed back to the CPU.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/ram_loader.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the RAM loader/dumper.
// Holds the loader FSM encoding, the mode values sampled with start, and the default last address.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } loader_state_e;

  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_DUMP = 1'b1;

  localparam int RAM_DEPTH = 16;
  localparam int LAST_ADDR = RAM_DEPTH - 1;

endpackage

// File: rtl/ram_loader.sv
// RAM bus initiator: streams a full image into the RAM (LOAD) or reads it all back out (DUMP).
// Owns the RAM bus only while busy is high; the integration mux uses busy as its select.
module ram_loader
  import loader_pkg::*;
#(
  parameter int RAM_INPUT_ADDR = 4,
  parameter int RAM_SIZE       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      mode,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [7:0]                out_data,
  input  logic                      out_ready,
  output logic [RAM_INPUT_ADDR-1:0] ram_addr,
  output logic [7:0]                ram_wdata,
  output logic                      ram_in,
  output logic                      ram_out,
  input  logic [7:0]                ram_rdata,
  output logic                      busy,
  output logic                      done
);

  localparam logic [RAM_INPUT_ADDR-1:0] PTR_LAST = RAM_INPUT_ADDR'(RAM_SIZE - 1);
  localparam logic [RAM_INPUT_ADDR-1:0] PTR_ONE  = {{(RAM_INPUT_ADDR-1){1'b0}}, 1'b1};
  localparam logic [RAM_INPUT_ADDR-1:0] PTR_ZERO = {RAM_INPUT_ADDR{1'b0}};

  loader_state_e             state_r;
  loader_state_e             state_next_s;
  logic [RAM_INPUT_ADDR-1:0] ptr_r;
  logic [7:0]                wdata_r;
  logic [7:0]                odata_r;
  logic                      is_last_s;

  assign is_last_s = (ptr_r == PTR_LAST);

  // Next-state decode; the pointer never wraps because the last address exits to DONE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (mode == MODE_DUMP) begin
            state_next_s = ST_READ;
          end else begin
            state_next_s = ST_LOAD;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_WRITE: begin
        if (is_last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_READ: state_next_s = ST_OUT;
      ST_OUT: begin
        if (!out_ready) begin
          state_next_s = ST_OUT;
        end else if (is_last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_READ;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register plus bus strobes registered from the next state, so they align with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      in_ready  <= 1'b0;
      ram_in    <= 1'b0;
      ram_out   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      in_ready  <= (state_next_s == ST_LOAD);
      ram_in    <= (state_next_s == ST_WRITE);
      ram_out   <= (state_next_s == ST_READ);
      out_valid <= (state_next_s == ST_OUT);
      busy      <= (state_next_s != ST_IDLE);
      done      <= (state_next_s == ST_DONE);
    end
  end

  // Pointer and data registers; out_data only moves in READ, so it holds through OUT stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r   <= PTR_ZERO;
      wdata_r <= 8'h00;
      odata_r <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: ptr_r <= PTR_ZERO;
        ST_LOAD: begin
          if (in_valid) begin
            wdata_r <= in_data;
          end
        end
        ST_WRITE: begin
          if (!is_last_s) begin
            ptr_r <= ptr_r + PTR_ONE;
          end
        end
        ST_READ: odata_r <= ram_rdata;
        ST_OUT: begin
          if (out_ready && !is_last_s) begin
            ptr_r <= ptr_r + PTR_ONE;
          end
        end
        default: ptr_r <= ptr_r;
      endcase
    end
  end

  assign ram_addr  = ptr_r;
  assign ram_wdata = wdata_r;
  assign out_data  = odata_r;

endmodule
